// File: rtl/clock_divider_multi.sv
// NUM_CH independent shadowed clock dividers with common sync restart.
// Define CLKDIV_DUTY_EN to add per-channel duty-cycle mode (ports mode, duty_in).
module clock_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NUM_CH-1:0]       en,
  input  logic                    sync,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] divisor_in,
`ifdef CLKDIV_DUTY_EN
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH*CNT_W-1:0] duty_in,
`endif
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] count, count_inc, div_act, shadow, din;
    logic             term, apply, out_run;
    logic             out_q, tick_q, pend_q;

    assign din       = divisor_in[g*CNT_W +: CNT_W];
    assign count_inc = count + 1'b1;
    assign term      = (count == div_act);
    // Shadow is committed only where the counter restarts from zero.
    assign apply     = pend_q & (sync | term);

`ifdef CLKDIV_DUTY_EN
    logic [CNT_W-1:0] duty_act, duty_sh, duty_new, ddin;
    logic             mode_act;

    assign ddin     = duty_in[g*CNT_W +: CNT_W];
    assign duty_new = apply ? duty_sh : duty_act;

    always_comb begin
      out_run = out_q;
      if (term)          out_run = mode[g] ? (duty_new != '0) : ~out_q;
      else if (mode_act) out_run = (count_inc < duty_act);
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        duty_act <= '0;
        duty_sh  <= '0;
        mode_act <= 1'b0;
      end else begin
        if (!en[g] || sync || term) mode_act <= mode[g];
        if (!en[g]) begin
          if (load[g]) begin
            duty_act <= ddin;
            duty_sh  <= ddin;
          end
        end else begin
          if (apply)   duty_act <= duty_sh;
          if (load[g]) duty_sh  <= ddin;
        end
      end
    end
`else
    assign out_run = term ? ~out_q : out_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        count   <= '0;
        div_act <= CNT_W'(DEFAULT_DIV);
        shadow  <= CNT_W'(DEFAULT_DIV);
        pend_q  <= 1'b0;
        out_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else if (!en[g]) begin
        count  <= '0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
        // While idle there is no period to protect, so a load lands directly.
        if (load[g]) begin
          shadow  <= din;
          div_act <= din;
          pend_q  <= 1'b0;
        end
      end else begin
        if (apply)   div_act <= shadow;
        if (load[g]) shadow  <= din;
        pend_q <= load[g] | (pend_q & ~apply);
        if (sync) begin
          count  <= '0;
          out_q  <= 1'b0;
          tick_q <= 1'b0;
        end else if (term) begin
          count  <= '0;
          out_q  <= out_run;
          tick_q <= 1'b1;
        end else begin
          count  <= count_inc;
          out_q  <= out_run;
          tick_q <= 1'b0;
        end
      end
    end

    assign clk_out[g] = out_q;
    assign tick[g]    = tick_q;
    assign pending[g] = pend_q;
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: per-cycle model comparison plus pinned literal checks.
// Define CLKDIV_DUTY_EN to also exercise duty mode.
module tb_clock_divider_multi;
  localparam int NC = 4;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [NC-1:0]   en = '0;
  logic            sync = 1'b0;
  logic [NC-1:0]   load = '0;
  logic [NC*CW-1:0] divisor_in = '0;
  logic [NC-1:0]   clk_out, tick, pending;
`ifdef CLKDIV_DUTY_EN
  logic [NC-1:0]   mode = '0;
  logic [NC*CW-1:0] duty_in = '0;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  clock_divider_multi #(.NUM_CH(NC), .CNT_W(CW), .DEFAULT_DIV(0)) dut (
    .clk(clk), .resetn(resetn), .en(en), .sync(sync), .load(load),
    .divisor_in(divisor_in),
`ifdef CLKDIV_DUTY_EN
    .mode(mode), .duty_in(duty_in),
`endif
    .clk_out(clk_out), .tick(tick), .pending(pending));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_tot++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  // Model: each channel holds "cycles elapsed in current phase" and the phase
  // length; a phase ends after div+1 enabled edges.
  int m_el[NC], m_div[NC], m_sh[NC], m_duty[NC], m_dsh[NC];
  bit m_pend[NC], m_out[NC], m_tick[NC], m_mode[NC];

  initial forever begin
    @(posedge clk or negedge resetn);
    for (int i = 0; i < NC; i++) begin
      int d, dd;
      bit md;
      d  = int'(divisor_in[i*CW +: CW]);
      dd = 0;
      md = 1'b0;
`ifdef CLKDIV_DUTY_EN
      dd = int'(duty_in[i*CW +: CW]);
      md = mode[i];
`endif
      if (!resetn) begin
        m_el[i] = 0; m_div[i] = 0; m_sh[i] = 0; m_duty[i] = 0; m_dsh[i] = 0;
        m_pend[i] = 0; m_out[i] = 0; m_tick[i] = 0; m_mode[i] = 0;
      end else if (!en[i]) begin
        m_el[i] = 0; m_out[i] = 0; m_tick[i] = 0; m_mode[i] = md;
        if (load[i]) begin
          m_div[i] = d; m_sh[i] = d; m_duty[i] = dd; m_dsh[i] = dd; m_pend[i] = 0;
        end
      end else if (sync || m_el[i] + 1 == m_div[i] + 1) begin
        if (m_pend[i]) begin m_div[i] = m_sh[i]; m_duty[i] = m_dsh[i]; end
        m_pend[i] = load[i];
        if (load[i]) begin m_sh[i] = d; m_dsh[i] = dd; end
        m_el[i] = 0;
        m_mode[i] = md;
        if (sync) begin
          m_out[i] = 0; m_tick[i] = 0;
        end else begin
          m_tick[i] = 1;
          m_out[i] = md ? (m_duty[i] > 0) : !m_out[i];
        end
      end else begin
        m_el[i] = m_el[i] + 1;
        m_tick[i] = 0;
        if (m_mode[i]) m_out[i] = (m_el[i] < m_duty[i]);
        if (load[i]) begin m_sh[i] = d; m_dsh[i] = dd; m_pend[i] = 1; end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      chk($sformatf("model clk_out[%0d]", i), int'(clk_out[i]), int'(m_out[i]));
      chk($sformatf("model tick[%0d]", i),    int'(tick[i]),    int'(m_tick[i]));
      chk($sformatf("model pending[%0d]", i), int'(pending[i]), int'(m_pend[i]));
    end
  end

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_div(input int ch, input int v);
    divisor_in[ch*CW +: CW] = CW'(v);
  endtask

`ifdef CLKDIV_DUTY_EN
  task automatic count_high(input int n, output int s);
    s = 0;
    repeat (n) begin
      adv(1);
      s += int'(clk_out[0]);
    end
  endtask
`endif

  initial begin
    adv(2);
    chk("reset clk_out", int'(clk_out), 0);
    chk("reset tick", int'(tick), 0);
    chk("reset pending", int'(pending), 0);
    resetn = 1'b1;

    // Toggle basics: ch0 div 3, ch1 div 0, ch2 div 15 (full-width wrap)
    load = 4'b0101; set_div(0, 3); set_div(2, 15);
    adv(1);
    load = '0;
    chk("idle load no pending", int'(pending), 0);
    en = 4'b0111;
    adv(1);
    chk("div0 first toggle", int'(clk_out[1]), 1);
    chk("div0 tick", int'(tick[1]), 1);
    adv(2);
    chk("div3 E3 low", int'(clk_out[0]), 0);
    adv(1);
    chk("div3 E4 high", int'(clk_out[0]), 1);
    chk("div3 E4 tick", int'(tick[0]), 1);
    adv(1);
    chk("div3 E5 tick clr", int'(tick[0]), 0);
    adv(3);
    chk("div3 E8 low", int'(clk_out[0]), 0);
    chk("div3 E8 tick", int'(tick[0]), 1);
    adv(7);
    chk("div15 E15 low", int'(clk_out[2]), 0);
    adv(1);
    chk("div15 E16 high", int'(clk_out[2]), 1);
    adv(16);
    chk("div15 E32 low", int'(clk_out[2]), 0);
    chk("div15 E32 tick", int'(tick[2]), 1);

    // Running div 9, shrink to 2 at count 5
    load[3] = 1'b1; set_div(3, 9);
    adv(1);
    load = '0; en[3] = 1'b1;
    adv(5);
    load[3] = 1'b1; set_div(3, 2);
    adv(1);
    load = '0;
    chk("shrink pending", int'(pending[3]), 1);
    adv(3);
    chk("shrink E9 pending", int'(pending[3]), 1);
    chk("shrink E9 low", int'(clk_out[3]), 0);
    adv(1);
    chk("shrink E10 applied", int'(pending[3]), 0);
    chk("shrink E10 high", int'(clk_out[3]), 1);
    adv(2);
    chk("shrink E12 high", int'(clk_out[3]), 1);
    adv(1);
    chk("shrink E13 low", int'(clk_out[3]), 0);
    chk("shrink E13 tick", int'(tick[3]), 1);

    // Load coincident with terminal count
    load[3] = 1'b1; set_div(3, 4);
    adv(1);
    load = '0;
    adv(1);
    load[3] = 1'b1; set_div(3, 6);
    adv(1);
    load = '0;
    chk("coinc tick", int'(tick[3]), 1);
    chk("coinc still pending", int'(pending[3]), 1);
    adv(4);
    chk("coinc E20 no tick", int'(tick[3]), 0);
    adv(1);
    chk("coinc E21 tick", int'(tick[3]), 1);
    chk("coinc E21 applied", int'(pending[3]), 0);
    adv(6);
    chk("coinc E27 no tick", int'(tick[3]), 0);
    adv(1);
    chk("coinc E28 tick", int'(tick[3]), 1);

    // Sync alignment of two staggered div-1 channels
    en[1:0] = 2'b00; load[1:0] = 2'b11; set_div(0, 1); set_div(1, 1);
    adv(1);
    load = '0;
    chk("disabled low", int'(clk_out[1:0]), 0);
    en[0] = 1'b1;
    adv(1);
    en[1] = 1'b1;
    adv(2);
    sync = 1'b1;
    adv(1);
    sync = 1'b0;
    chk("sync clk_out", int'(clk_out), 0);
    chk("sync tick", int'(tick), 0);
    adv(1);
    chk("post sync low", int'(clk_out[1:0]), 0);
    adv(1);
    chk("aligned toggle", int'(clk_out[1:0]), 3);
    chk("aligned tick", int'(tick[1:0]), 3);
    adv(1);
    en[0] = 1'b0;
    adv(1);
    chk("disable mid-period", int'(clk_out[0]), 0);
    en[0] = 1'b1;

    // Sync applies pending shadow and captures a coincident load
    load[2] = 1'b1; set_div(2, 5);
    adv(1);
    load = '0;
    chk("pre-sync pending", int'(pending[2]), 1);
    sync = 1'b1; load[3] = 1'b1; set_div(3, 7);
    adv(1);
    sync = 1'b0; load = '0;
    chk("sync applied", int'(pending[2]), 0);
    chk("sync captured", int'(pending[3]), 1);
    adv(20);

    // Asynchronous reset mid-period
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async reset clk_out", int'(clk_out), 0);
    chk("async reset tick", int'(tick), 0);
    chk("async reset pending", int'(pending), 0);
    en = '0; load = '0; sync = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

`ifdef CLKDIV_DUTY_EN
    begin
      int s;
      mode[0] = 1'b1;
      load[0] = 1'b1; set_div(0, 9); duty_in[0 +: CW] = 4'd3;
      adv(1);
      load = '0; en[0] = 1'b1;
      adv(10);
      chk("duty E10 high", int'(clk_out[0]), 1);
      chk("duty E10 tick", int'(tick[0]), 1);
      adv(2);
      chk("duty E12 high", int'(clk_out[0]), 1);
      adv(1);
      chk("duty E13 low", int'(clk_out[0]), 0);
      adv(6);
      chk("duty E19 low", int'(clk_out[0]), 0);
      adv(1);
      chk("duty E20 high", int'(clk_out[0]), 1);
      count_high(20, s);
      chk("duty 3/10 highs", s, 6);
      load[0] = 1'b1; duty_in[0 +: CW] = 4'd0;
      adv(1);
      load = '0;
      adv(10);
      count_high(20, s);
      chk("duty 0 highs", s, 0);
      load[0] = 1'b1; duty_in[0 +: CW] = 4'd12;
      adv(1);
      load = '0;
      adv(10);
      count_high(20, s);
      chk("duty 12 highs", s, 20);
      #2 resetn = 1'b0;
      #1;
      chk("duty async reset clk_out", int'(clk_out), 0);
      chk("duty async reset tick", int'(tick), 0);
      @(negedge clk);
      resetn = 1'b1;
      adv(2);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
